// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider for the EX stage (DIV / DIVU).
// One quotient bit is produced per clock, MSB first, working on operand
// magnitudes; the signs are applied once all bits are in.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request level, held high by EX until ready_o
//   annul_i       abort the division in flight
//   result_o      {remainder, quotient}; upper half to HI, lower half to LO
//   ready_o       result_o valid
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BYZERO,
    DIV_ON,
    DIV_END
  } divState_t;

  divState_t           r_state;
  divState_t           w_nextState;

  logic [CNT_W-1:0]    r_count;
  logic                r_signed;
  logic                r_dvdNeg;
  logic                r_dvsNeg;
  logic [DATA_W-1:0]   r_dvd;
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quot;
  logic [2*DATA_W-1:0] r_result;

  logic                w_accept;
  logic [DATA_W-1:0]   w_absDvd;
  logic [DATA_W-1:0]   w_absDvs;
  logic [DATA_W:0]     w_trial;
  logic [DATA_W-1:0]   w_sub;
  logic                w_quotBit;
  logic [DATA_W-1:0]   w_remNext;
  logic [DATA_W-1:0]   w_quotFixed;
  logic [DATA_W-1:0]   w_remFixed;

  // A request is taken only from DIV_FREE and only when not being annulled.
  assign w_accept = start_i && !annul_i;

  // Magnitudes are taken only for signed negatives; 0x80..0 negates to itself,
  // which is the correct magnitude when read as unsigned.
  assign w_absDvd = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_absDvs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Restoring step: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits. When it fits, the difference is below the
  // divisor, so the low DATA_W bits of the subtraction are exact.
  assign w_trial   = {r_rem, r_dvd[DATA_W-1]};
  assign w_quotBit = (w_trial >= {1'b0, r_dvs});
  assign w_sub     = w_trial[DATA_W-1:0] - r_dvs;
  assign w_remNext = w_quotBit ? w_sub : w_trial[DATA_W-1:0];

  // Quotient is negative when operand signs differ; remainder follows dividend.
  assign w_quotFixed = (r_signed && (r_dvdNeg ^ r_dvsNeg)) ? -r_quot : r_quot;
  assign w_remFixed  = (r_signed && r_dvdNeg) ? -r_rem : r_rem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      DIV_FREE: begin
        if (w_accept) begin
          w_nextState = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        w_nextState = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          w_nextState = DIV_FREE;
        end else if (r_count == LAST_CNT) begin
          w_nextState = DIV_END;
        end
      end
      DIV_END: begin
        if (!start_i) begin
          w_nextState = DIV_FREE;
        end
      end
      default: w_nextState = DIV_FREE;
    endcase
  end

  // Outputs: ready is a pure decode of the registered state, and the result
  // register is kept at zero whenever the unit is not in DIV_END.
  always_comb begin
    ready_o  = (r_state == DIV_END);
    result_o = r_result;
  end

  // Datapath registers: operand capture, iteration and result load/clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_signed <= 1'b0;
      r_dvdNeg <= 1'b0;
      r_dvsNeg <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (w_accept) begin
            r_count  <= '0;
            r_signed <= signed_div_i;
            r_dvdNeg <= opdata1_i[DATA_W-1];
            r_dvsNeg <= opdata2_i[DATA_W-1];
            r_dvd    <= w_absDvd;
            r_dvs    <= w_absDvs;
            r_rem    <= '0;
            r_quot   <= '0;
          end
          r_result <= '0;
        end
        DIV_BYZERO: begin
          r_result <= '0;
        end
        DIV_ON: begin
          if (annul_i) begin
            r_result <= '0;
          end else if (r_count != LAST_CNT) begin
            r_rem   <= w_remNext;
            r_dvd   <= {r_dvd[DATA_W-2:0], 1'b0};
            r_quot  <= {r_quot[DATA_W-2:0], w_quotBit};
            r_count <= r_count + 1'b1;
          end else begin
            r_result <= {w_remFixed, w_quotFixed};
          end
        end
        DIV_END: begin
          if (!start_i) begin
            r_result <= '0;
          end
        end
        default: r_result <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Scoreboard bench for div_unit. Stimulus pushes the expected result when it
// issues a request; a separate monitor pops and compares when ready_o rises
// and keeps comparing while the result is held.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] expQ[$];
  logic [63:0] heldExp = 64'd0;
  bit          prevReady = 1'b0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Compare helper shared by stimulus and monitor.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer division with truncation toward zero,
  // so the remainder carries the dividend's sign; x/0 yields zero.
  function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint na;
    longint nb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: pops on the rising edge of ready_o, then checks the held value.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ready_o && !prevReady) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_ready actual=%h expected=no_result", result_o);
        end else begin
          heldExp = expQ.pop_front();
          checkOutput("result", result_o, heldExp);
        end
      end else if (!rst && ready_o && prevReady) begin
        checkOutput("result_held", result_o, heldExp);
      end
      prevReady = ready_o && !rst;
    end
  end

  // Issues one request, checks latency, optionally holds start, then releases
  // (or resets) and checks that the outputs clear one edge later.
  task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp, input int holdExtra,
                               input bit preAnnul, input bit useReset);
    int edges;
    bit got;
    int expLat;
    expQ.push_back(exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (preAnnul) begin
      annul_i = 1'b1;
      @(posedge clk); #1;
      checkOutput("annul_in_free_ready", {63'd0, ready_o}, 64'd0);
      annul_i = 1'b0;
    end
    edges  = -1;
    got    = 1'b0;
    expLat = (b == 32'd0) ? 1 : 33;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 0) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
      if (ready_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout actual=none expected=%0d_edges", expLat);
    end else begin
      checkOutput("latency", 64'(edges), 64'(expLat));
    end
    repeat (holdExtra) begin
      @(posedge clk); #1;
    end
    if (useReset) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("reset_in_end_ready", {63'd0, ready_o}, 64'd0);
      checkOutput("reset_in_end_result", result_o, 64'd0);
      start_i = 1'b0;
      @(posedge clk); #1;
    end else begin
      start_i = 1'b0;
      @(posedge clk); #1;
      checkOutput("release_ready", {63'd0, ready_o}, 64'd0);
      checkOutput("release_result", result_o, 64'd0);
    end
  endtask

  initial begin
    bit          sawReady;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations
    applyStimulus(1'b0, 32'd100,      32'd7,          64'h00000002_0000000E, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000007, 32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd50,       32'd0,          64'h00000000_00000000, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd50,       32'd0,          64'h00000000_00000000, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF,   64'h00000000_80000000, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h00000001,   64'h00000000_FFFFFFFF, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd5,        32'd9,          64'h00000005_00000000, 0, 1'b0, 1'b0);

    // start with annul in DIV_FREE is ignored; latency counts from later edge
    applyStimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 1'b1, 1'b0);

    // Annul during iteration 10: no result ever appears
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    checkOutput("annul_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("annul_result", result_o, 64'd0);
    sawReady = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      sawReady |= ready_o;
    end
    checkOutput("annul_no_ready", {63'd0, sawReady}, 64'd0);
    applyStimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 1'b0, 1'b0);

    // Reset in the middle of an iteration
    signed_div_i = 1'b1;
    opdata1_i    = 32'd1234;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    start_i = 1'b0;
    checkOutput("reset_in_on_ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset_in_on_result", result_o, 64'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 0, 1'b0, 1'b0);

    // Reset while the result is held in DIV_END
    applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0, 1'b0, 1'b0);

    // Randomized requests against the reference model
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 200));
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel <= 3) begin
        b = 32'($urandom_range(1, 15));
        if (sgn && $urandom_range(0, 1) == 1) b = -b;
      end else begin
        b = $urandom;
      end
      applyStimulus(sgn, a, b, refDiv(sgn, a, b), $urandom_range(0, 3), 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle iterative divider serving the EX stage for DIV/DIVU.
- EX raises start_i with operands and holds its pipeline stall request until ready_o.
- EX then forwards result_o to HI/LO via hi_o/lo_o with whilo_o set.
- One quotient bit per cycle, MSB first (restoring division).
- ID-stage branch-delay annul is supported via annul_i.

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W; result width is 2*DATA_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset rst, synchronous, active-high
signed_div_i  in  1  1 = signed DIV, 0 = unsigned DIVU
opdata1_i  in  DATA_W  dividend
opdata2_i  in  DATA_W  divisor
start_i  in  1  division request; level, held high by EX while stalled
annul_i  in  1  abort current division
result_o  out  2*DATA_W  {remainder, quotient}; [63:32] goes to HI, [31:0] goes to LO
ready_o  out  1  result_o valid

Behaviour:
- All state is registered. Reset (rst=1 at an edge) forces state=DIV_FREE, ready_o=0, result_o=0, iteration count=0. This applies from any state, including mid-division.
- States: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END.
- DIV_FREE:
  - If start_i=1 and annul_i=0: latch signed_div_i.
  - If the divisor is 0, go to DIV_BYZERO.
  - Otherwise go to DIV_ON with count=0. Load |dividend| and |divisor|; absolute values are taken only when signed_div_i=1 and the MSB=1, else raw bits. |-2^31| = 0x80000000 treated as unsigned.
  - start_i with annul_i=1 is ignored; stay in DIV_FREE.
- DIV_BYZERO: next edge goes to DIV_END with result_o=0, ready_o=1. If annul_i=1, go to DIV_FREE instead.
- DIV_ON, count<DATA_W, annul_i=0, each edge:
  - Partial remainder R := {R[DATA_W-1:0], next dividend bit}.
  - If R >= divisor: R -= divisor, quotient bit=1; else quotient bit=0.
  - count += 1.
- DIV_ON, count==DATA_W:
  - Apply sign fix. If signed and the operand signs differ, quotient := -quotient. If signed and the dividend is negative, remainder := -remainder (remainder sign follows dividend).
  - Load result_o, set ready_o=1, go to DIV_END.
- annul_i=1 in DIV_ON: next edge goes to DIV_FREE, ready_o=0, result_o=0. The partial result is discarded.
- DIV_END:
  - ready_o=1 and result_o are held stable while start_i=1.
  - At the first edge with start_i=0: go to DIV_FREE, ready_o=0, result_o=0.
  - annul_i has no effect in DIV_END.
- Operand or signed_div_i changes after acceptance are ignored. start_i in DIV_ON is ignored (no restart).
- Latency, with the accepting edge as edge 0:
  - Normal: iterations on edges 1..DATA_W; ready_o=1 after edge DATA_W+1 (33 for DATA_W=32).
  - Divide by zero: ready_o=1 after edge 1.
- Back-to-back requests: a new request is accepted only from DIV_FREE, so at least one cycle of start_i=0 separates them.
- No overflow trap. 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0.

Test Plan:
- Unsigned 100/7: start at edge 0. ready_o rises after edge 33; result_o=0x00000002_0000000E. Held until start_i drops; one edge later ready_o=0 and result_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero (50/0, unsigned) -> ready_o=1 after edge 1, result_o=0. Same with signed_div_i=1.
- Boundary values:
  - Signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
  - Unsigned 5/9 -> 0x00000005_00000000.
- annul_i pulsed during iteration 10 -> DIV_FREE next edge, ready_o never asserts. A following start of 100/7 completes normally in 33 edges.
- rst asserted mid-DIV_ON and again in DIV_END -> next edge ready_o=0, result_o=0, state DIV_FREE. Operand changes during DIV_ON do not alter the result.
